// File: rtl/iic_bit_driver.sv
// Bit-level IIC master line driver: runs one START/STOP/WRITE/READ bit as four
// quarter-period phases on open-drain enables, with clock stretching and arbitration.
`ifndef GCLK_FREQ
`define GCLK_FREQ 50000000
`endif

module iic_bit_driver #(
   parameter int CLK_FREQ = `GCLK_FREQ,
   parameter int SCL_FREQ = 100000
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       Cmd_Valid,
   output logic       Cmd_Ready,
   input  logic [1:0] Cmd,
   input  logic       Tx_Bit,
   output logic       Rx_Bit,
   output logic       Done,
   output logic       Arb_Lost,
   input  logic       SCL_In,
   input  logic       SDA_In,
   output logic       SCL_Oe,
   output logic       SDA_Oe
);

   // QUARTER must be at least 2 so that the phase counter has a distinct last cycle.
   localparam int QUARTER = CLK_FREQ / (4 * SCL_FREQ);
   localparam int CNT_W   = (QUARTER > 2) ? $clog2(QUARTER) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUARTER - 1);

   typedef enum logic [2:0] {IDLE, PH_A, PH_B, PH_C, PH_D} state_t;
   typedef enum logic [1:0] {CMD_START, CMD_STOP, CMD_WRITE, CMD_READ} cmd_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   cmd_t             cmd_q, cmd_d;
   logic             tx_q, tx_d;
   logic             scl_oe_q, scl_oe_d;
   logic             sda_oe_q, sda_oe_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic             rx_q, rx_d;
   logic             arb_q, arb_d;

   logic             stall;
   logic             last;
   state_t           next_ph;

   // Returns {scl_oe, sda_oe} to drive while in phase ph of command c.
   function automatic logic [1:0] phase_oe(input cmd_t c, input logic tx, input state_t ph);
      logic scl;
      logic sda;
      scl = (ph == PH_A) || (ph == PH_D);
      sda = 1'b0;
      case (c)
         CMD_START: sda = (ph == PH_C) || (ph == PH_D);
         CMD_STOP: begin
            scl = (ph == PH_A);
            sda = (ph == PH_A) || (ph == PH_B);
         end
         CMD_WRITE: sda = ~tx;
         default:   sda = 1'b0;
      endcase
      return {scl, sda};
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cmd_d    = cmd_q;
      tx_d     = tx_q;
      scl_oe_d = scl_oe_q;
      sda_oe_d = sda_oe_q;
      ready_d  = ready_q;
      done_d   = 1'b0;
      rx_d     = rx_q;
      arb_d    = arb_q;

      last  = (cnt_q == CNT_LAST);
      stall = (state_q == PH_B) && (cnt_q == '0) && !SCL_In;

      case (state_q)
         PH_A:    next_ph = PH_B;
         PH_B:    next_ph = PH_C;
         PH_C:    next_ph = PH_D;
         default: next_ph = IDLE;
      endcase

      if (state_q == IDLE) begin
         if (Cmd_Valid) begin
            cmd_d   = cmd_t'(Cmd);
            tx_d    = Tx_Bit;
            arb_d   = 1'b0;
            ready_d = 1'b0;
            cnt_d   = '0;
            state_d = PH_A;
            {scl_oe_d, sda_oe_d} = phase_oe(cmd_t'(Cmd), Tx_Bit, PH_A);
         end
      end else if (!stall) begin
         if (!last) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else begin
            cnt_d   = '0;
            state_d = next_ph;
            if (next_ph == IDLE) begin
               done_d  = 1'b1;
               ready_d = 1'b1;
            end else begin
               {scl_oe_d, sda_oe_d} = phase_oe(cmd_q, tx_q, next_ph);
            end
            // A released SDA seen low while SCL is high means another master won.
            if ((cmd_q == CMD_WRITE) && tx_q && !SDA_In &&
                ((state_q == PH_B) || (state_q == PH_C)))
               arb_d = 1'b1;
            if ((cmd_q == CMD_READ) && (state_q == PH_C))
               rx_d = SDA_In;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cmd_q    <= CMD_START;
         tx_q     <= 1'b0;
         scl_oe_q <= 1'b0;
         sda_oe_q <= 1'b0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         rx_q     <= 1'b0;
         arb_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cmd_q    <= cmd_d;
         tx_q     <= tx_d;
         scl_oe_q <= scl_oe_d;
         sda_oe_q <= sda_oe_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         rx_q     <= rx_d;
         arb_q    <= arb_d;
      end
   end

   assign Cmd_Ready = ready_q;
   assign Done      = done_q;
   assign Rx_Bit    = rx_q;
   assign Arb_Lost  = arb_q;
   assign SCL_Oe    = scl_oe_q;
   assign SDA_Oe    = sda_oe_q;

endmodule
